regfile_write_arbiter: RTL

Shares the register file's single write port between the pipeline writeback stage (WB) and the multi-cycle multiply/divide unit (MD). MD results are queued in a small FIFO and retired into free write-port cycles. A starvation counter stalls the pipeline for one cycle when the queue has waited too long. A combinational scoreboard query reports pending MD writes so the hazard unit can stall dependent instructions.

---
 rtl/regfile_write_arbiter_pkg.sv | 11 +
 rtl/regfile_write_fifo.sv | 98 +++++++++
 rtl/regfile_write_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants used by the write arbiter, the register file
// and the hazard unit.
package regfile_write_arbiter_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    // Architectural zero register: writes to it are dropped, lookups never hit.
    localparam logic [RF_ADDR_WIDTH-1:0] RF_REG_ZERO = '0;

endpackage

// File: rtl/regfile_write_fifo.sv
// Small synchronous FIFO holding MD results waiting for a free write-port
// cycle. It also exposes a per-entry "valid and register matches" vector for
// two lookup registers, which the arbiter uses as its pending-write scoreboard.
//
// Ports:
//   Clk, Reset_n           clock, asynchronous active-low reset
//   push, pushReg/Data     enqueue one entry (caller guarantees not full)
//   pop                    dequeue the head (caller guarantees not empty)
//   headReg, headData      current head entry (combinational)
//   count                  occupancy, 0..DEPTH
//   cmpReg1, cmpReg2       registers to look up
//   cmpHit1, cmpHit2       per-entry match vectors (combinational)
module regfile_write_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       push,
    input  logic [ADDR_WIDTH-1:0]      pushReg,
    input  logic [DATA_WIDTH-1:0]      pushData,
    input  logic                       pop,
    output logic [ADDR_WIDTH-1:0]      headReg,
    output logic [DATA_WIDTH-1:0]      headData,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_WIDTH-1:0]      cmpReg1,
    input  logic [ADDR_WIDTH-1:0]      cmpReg2,
    output logic [DEPTH-1:0]           cmpHit1,
    output logic [DEPTH-1:0]           cmpHit2
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] entryReg  [DEPTH];
    logic [DATA_WIDTH-1:0] entryData [DEPTH];
    logic [DEPTH-1:0]      entryValid;
    logic [DEPTH-1:0]      validNext;
    logic [PTR_WIDTH-1:0]  wrPtr;
    logic [PTR_WIDTH-1:0]  rdPtr;

    // Payload storage needs no reset; entryValid guards every use of it.
    always_ff @(posedge Clk) begin
        if (push) begin
            entryReg[wrPtr]  <= pushReg;
            entryData[wrPtr] <= pushData;
        end
    end

    // Per-entry valid bits track exactly which slots hold a pending write.
    always_comb begin
        validNext = entryValid;
        if (pop) begin
            validNext[rdPtr] = 1'b0;
        end
        if (push) begin
            validNext[wrPtr] = 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
        end else begin
            entryValid <= validNext;
            if (push) begin
                wrPtr <= wrPtr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    assign headReg  = entryReg[rdPtr];
    assign headData = entryData[rdPtr];

    // Scoreboard lookup across all valid entries.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            cmpHit1[i] = entryValid[i] && (entryReg[i] == cmpReg1);
            cmpHit2[i] = entryValid[i] && (entryReg[i] == cmpReg2);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the pipeline WB stage
// and the multiply/divide unit. MD results queue in a small FIFO and drain
// into cycles WB leaves free; a starvation counter forces a one-cycle
// pipeline stall so a queued MD result cannot wait forever.
//
// Ports:
//   Clk, Reset_n                     clock, asynchronous active-low reset
//   WbValid, WbReg, WbData           WB stage write request
//   MdValid, MdReady, MdReg, MdData  MD result handshake
//   StallPipe                        registered one-cycle pipeline freeze
//   QueryReg1/2, QueryHit1/2         pending-MD-write lookup (combinational)
//   RfRegWrite, RfWriteRegister,
//   RfWriteData                      registered register-file write port
//   Pending                          MD queue occupancy
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = RF_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          WbValid,
    input  logic [ADDR_WIDTH-1:0]         WbReg,
    input  logic [DATA_WIDTH-1:0]         WbData,
    input  logic                          MdValid,
    output logic                          MdReady,
    input  logic [ADDR_WIDTH-1:0]         MdReg,
    input  logic [DATA_WIDTH-1:0]         MdData,
    output logic                          StallPipe,
    input  logic [ADDR_WIDTH-1:0]         QueryReg1,
    input  logic [ADDR_WIDTH-1:0]         QueryReg2,
    output logic                          QueryHit1,
    output logic                          QueryHit2,
    output logic                          RfRegWrite,
    output logic [ADDR_WIDTH-1:0]         RfWriteRegister,
    output logic [DATA_WIDTH-1:0]         RfWriteData,
    output logic [$clog2(FIFO_DEPTH):0]   Pending
);

    localparam int unsigned CNT_WIDTH    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = ADDR_WIDTH'(RF_REG_ZERO);

    logic                    wbReq;
    logic                    mdPush;
    logic                    fifoNonEmpty;
    logic                    popGrant;
    logic                    wbGrant;
    logic [ADDR_WIDTH-1:0]   headReg;
    logic [DATA_WIDTH-1:0]   headData;
    logic [FIFO_DEPTH-1:0]   fifoHit1;
    logic [FIFO_DEPTH-1:0]   fifoHit2;
    logic [STARVE_WIDTH-1:0] starveCnt;
    logic [STARVE_WIDTH-1:0] starveNext;
    logic                    stallNext;
    logic                    rfFromMd;

    regfile_write_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uFifo (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .push     (mdPush),
        .pushReg  (MdReg),
        .pushData (MdData),
        .pop      (popGrant),
        .headReg  (headReg),
        .headData (headData),
        .count    (Pending),
        .cmpReg1  (QueryReg1),
        .cmpReg2  (QueryReg2),
        .cmpHit1  (fifoHit1),
        .cmpHit2  (fifoHit2)
    );

    // Ready uses pre-pop occupancy: a full queue never accepts, even when
    // it pops in the same cycle.
    assign MdReady      = Pending < CNT_WIDTH'(FIFO_DEPTH);
    assign fifoNonEmpty = Pending != '0;
    assign mdPush       = MdValid && MdReady && (MdReg != REG_ZERO);
    assign wbReq        = WbValid && (WbReg != REG_ZERO);

    // Write-port grant; during a forced stall the queue head takes the slot.
    always_comb begin
        popGrant = 1'b0;
        wbGrant  = 1'b0;
        if (StallPipe && fifoNonEmpty) begin
            popGrant = 1'b1;
        end else if (wbReq) begin
            wbGrant = 1'b1;
        end else if (fifoNonEmpty) begin
            popGrant = 1'b1;
        end
    end

    // Count WB wins over a waiting queue; the win that reaches the limit
    // arms the stall and restarts the count.
    always_comb begin
        starveNext = starveCnt;
        stallNext  = 1'b0;
        if (!fifoNonEmpty || popGrant) begin
            starveNext = '0;
        end else if (wbGrant) begin
            if (starveCnt == STARVE_WIDTH'(STARVE_LIMIT - 1)) begin
                starveNext = '0;
                stallNext  = 1'b1;
            end else begin
                starveNext = starveCnt + STARVE_WIDTH'(1);
            end
        end
    end

    // Registered write port, stall and starvation state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            StallPipe       <= 1'b0;
            starveCnt       <= '0;
            RfRegWrite      <= 1'b0;
            rfFromMd        <= 1'b0;
            RfWriteRegister <= '0;
            RfWriteData     <= '0;
        end else begin
            StallPipe  <= stallNext;
            starveCnt  <= starveNext;
            RfRegWrite <= popGrant || wbGrant;
            rfFromMd   <= popGrant;
            if (popGrant) begin
                RfWriteRegister <= headReg;
                RfWriteData     <= headData;
            end else if (wbGrant) begin
                RfWriteRegister <= WbReg;
                RfWriteData     <= WbData;
            end
        end
    end

    // An MD write stays pending until the register file has captured it,
    // which includes the cycle it sits on the Rf* outputs.
    assign QueryHit1 = (QueryReg1 != REG_ZERO)
                    && ((|fifoHit1)
                        || (RfRegWrite && rfFromMd && (RfWriteRegister == QueryReg1)));
    assign QueryHit2 = (QueryReg2 != REG_ZERO)
                    && ((|fifoHit2)
                        || (RfRegWrite && rfFromMd && (RfWriteRegister == QueryReg2)));

endmodule
